l2_mem_responder: RTL and testbench

L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

---
 rtl/l2_mem_responder_if.sv | 35 +++
 rtl/l2_mem_responder.sv | 137 +++++++++++++
 tb/tb_l2_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_mem_responder_if.sv
// Shared operation type and the request/response bundle between the dcache
// (master) and the L2 memory responder (slave).
package l2_mem_pkg;
    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;
endpackage

interface l2_mem_responder_if #(
    parameter int XLEN = 32
);
    import l2_mem_pkg::*;

    logic [XLEN-1:0]   l2_req_address;
    memory_operation_e l2_req_type;
    logic              l2_req_valid;
    logic [XLEN-1:0]   l2_word_to_store;
    logic [XLEN-1:0]   l2_fetched_word;
    logic              l2_req_fulfilled;
    logic              l2_busy;

    // Handshake: the master raises l2_req_valid and holds the request stable
    // until it sees the one-cycle l2_req_fulfilled pulse; the slave accepts only
    // while l2_busy is low and ignores the request lines while busy.
    modport master (
        output l2_req_address, l2_req_type, l2_req_valid, l2_word_to_store,
        input  l2_fetched_word, l2_req_fulfilled, l2_busy
    );

    modport slave (
        input  l2_req_address, l2_req_type, l2_req_valid, l2_word_to_store,
        output l2_fetched_word, l2_req_fulfilled, l2_busy
    );
endinterface

// File: rtl/l2_mem_responder.sv
// Fixed-latency word-addressed memory model answering dcache loads/stores.
// Unwritten or out-of-range words read back as DEFAULT_WORD.
module l2_mem_responder
    import l2_mem_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              MEM_DEPTH    = 256,
    parameter int              LATENCY      = 3,
    parameter logic [XLEN-1:0] DEFAULT_WORD = 32'hABAC_0012
) (
    input  logic              clk,
    input  logic              reset,
    l2_mem_responder_if.slave bus,
    output logic [1:0]        dbg_state
);
    localparam int         IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [XLEN-1:0]      addr_q, addr_d;
    logic [XLEN-1:0]      wdata_q, wdata_d;
    memory_operation_e    type_q, type_d;
    logic [XLEN-1:0]      fetched_q, fetched_d;
    logic [MEM_DEPTH-1:0] written_q, written_d;
    logic [XLEN-1:0]      mem_q [MEM_DEPTH];

    logic [XLEN-1:0]      op_addr;
    logic [XLEN-1:0]      op_wdata;
    memory_operation_e    op_type;
    logic [IDX_W-1:0]     op_idx;
    logic                 op_in_range;
    logic                 complete;
    logic                 mem_we;

    // With LATENCY=1 the access completes on the accepting edge, so the
    // operation comes straight from the bus rather than the latched copy.
    always_comb begin
        op_addr  = addr_q;
        op_wdata = wdata_q;
        op_type  = type_q;
        if (state_q == IDLE) begin
            op_addr  = bus.l2_req_address;
            op_wdata = bus.l2_word_to_store;
            op_type  = bus.l2_req_type;
        end
        op_idx      = op_addr[2 +: IDX_W];
        op_in_range = ((op_addr >> (IDX_W + 2)) == '0);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        type_d    = type_q;
        fetched_d = fetched_q;
        written_d = written_q;
        complete  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.l2_req_valid) begin
                    addr_d  = bus.l2_req_address;
                    wdata_d = bus.l2_word_to_store;
                    type_d  = bus.l2_req_type;
                    if (LATENCY == 1) begin
                        state_d  = RESPOND;
                        complete = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d  = RESPOND;
                    complete = 1'b1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The access itself happens on the edge that enters RESPOND.
        if (complete) begin
            if (op_type == LOAD) begin
                fetched_d = (op_in_range && written_q[op_idx]) ? mem_q[op_idx] : DEFAULT_WORD;
            end else if (op_in_range) begin
                written_d[op_idx] = 1'b1;
            end
        end
    end

    // An edge coinciding with reset must not commit a store.
    assign mem_we = complete && (op_type == STORE) && op_in_range && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            type_q    <= LOAD;
            fetched_q <= '0;
            written_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            type_q    <= type_d;
            fetched_q <= fetched_d;
            written_q <= written_d;
        end
    end

    // Storage is deliberately unreset; the written bits hide stale contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[op_idx] <= op_wdata;
        end
    end

    assign bus.l2_fetched_word  = fetched_q;
    assign bus.l2_req_fulfilled = (state_q == RESPOND);
    assign bus.l2_busy          = (state_q != IDLE);
    assign dbg_state            = state_q;
endmodule

// File: tb/tb_l2_mem_responder.sv
// Bench for l2_mem_responder: three instances (LATENCY 1, 3, 15) share clock
// and reset; a behavioural memory model feeds an expected-value queue.
module tb_l2_mem_responder;
    import l2_mem_pkg::*;

    localparam logic [31:0] DEF = 32'hABAC_0012;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]       addr_a      [3];
    memory_operation_e type_a      [3];
    logic              valid_a     [3];
    logic [31:0]       wdata_a     [3];
    logic [31:0]       fetched_a   [3];
    logic              fulfilled_a [3];
    logic              busy_a      [3];
    logic [1:0]        state_a     [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        l2_mem_responder_if #(.XLEN(32)) bus ();
        assign bus.l2_req_address   = addr_a[g];
        assign bus.l2_req_type      = type_a[g];
        assign bus.l2_req_valid     = valid_a[g];
        assign bus.l2_word_to_store = wdata_a[g];
        assign fetched_a[g]         = bus.l2_fetched_word;
        assign fulfilled_a[g]       = bus.l2_req_fulfilled;
        assign busy_a[g]            = bus.l2_busy;

        l2_mem_responder #(
            .XLEN(32),
            .MEM_DEPTH(256),
            .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 15)),
            .DEFAULT_WORD(DEF)
        ) dut (
            .clk(clk),
            .reset(rst),
            .bus(bus),
            .dbg_state(state_a[g])
        );
    end

    logic [31:0] model_mem [int];
    logic [31:0] last_fetch [3];
    logic [31:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 15);
    endfunction

    task automatic model_reset();
        model_mem.delete();
        for (int i = 0; i < 3; i++) last_fetch[i] = 32'h0;
    endtask

    // Behavioural memory: 256 words at address bits [9:2], higher bits = out of range.
    task automatic model_apply(input int d, input memory_operation_e op,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] exp);
        logic in_range;
        int   key;
        in_range = (addr[31:10] == 22'h0);
        key      = d * 256 + int'(addr[9:2]);
        if (op == LOAD) begin
            if (in_range && model_mem.exists(key)) exp = model_mem[key];
            else exp = DEF;
            last_fetch[d] = exp;
        end else begin
            if (in_range) model_mem[key] = wdata;
            exp = last_fetch[d];
        end
    endtask

    // One request on instance d; request lines are scrambled while busy.
    task automatic do_req(input int d, input memory_operation_e op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input string tag);
        logic [31:0] exp;
        int k;
        bit seen;
        model_apply(d, op, addr, wdata, exp);
        exp_q.push_back(exp);
        addr_a[d]  = addr;
        type_a[d]  = op;
        wdata_a[d] = wdata;
        valid_a[d] = 1'b1;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (fulfilled_a[d] === 1'b1) begin
                seen = 1'b1;
            end else begin
                addr_a[d]  = $urandom;
                wdata_a[d] = $urandom;
                type_a[d]  = memory_operation_e'($urandom_range(0, 1));
                valid_a[d] = ($urandom_range(0, 1) == 1);
            end
        end
        valid_a[d] = 1'b0;
        n_vec++;
        if (!seen || k != lat_of(d)) begin
            n_err++;
            $display("FAIL %s latency[%0d]: got %0d cycles, required %0d", tag, d, seen ? k : -1, lat_of(d));
        end
        exp = exp_q.pop_front();
        n_vec++;
        if (fetched_a[d] !== exp) begin
            n_err++;
            $display("FAIL %s data[%0d]: got %h, required %h", tag, d, fetched_a[d], exp);
        end
        @(negedge clk);
        n_vec++;
        if (fulfilled_a[d] !== 1'b0 || busy_a[d] !== 1'b0) begin
            n_err++;
            $display("FAIL %s pulse_end[%0d]: got fulfilled=%b busy=%b, required 0 0", tag, d, fulfilled_a[d], busy_a[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr_a[i]  = 32'h0;
            type_a[i]  = LOAD;
            valid_a[i] = 1'b0;
            wdata_a[i] = 32'h0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (fetched_a[i] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_fetched[%0d]: got %h, required 00000000", i, fetched_a[i]);
            end
            n_vec++;
            if (fulfilled_a[i] !== 1'b0 || busy_a[i] !== 1'b0 || state_a[i] !== 2'd0) begin
                n_err++;
                $display("FAIL reset_ctrl[%0d]: got fulfilled=%b busy=%b state=%0d, required 0 0 0",
                         i, fulfilled_a[i], busy_a[i], state_a[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_req(1, LOAD,  32'h0000_0040, 32'h0,         "load_unwritten");
        do_req(1, STORE, 32'h0000_0044, 32'hDEAD_BEEF, "store_44");
        do_req(1, LOAD,  32'h0000_0047, 32'h0,         "load_47");
        do_req(1, STORE, 32'h0001_0000, 32'h1234_5678, "store_oor");
        do_req(1, LOAD,  32'h0001_0000, 32'h0,         "load_oor");
        do_req(1, LOAD,  32'h0000_0000, 32'h0,         "load_idx0");
        do_req(0, STORE, 32'h0000_0008, 32'h5A5A_0101, "lat1_store");
        do_req(0, LOAD,  32'h0000_0009, 32'h0,         "lat1_load");
        do_req(2, STORE, 32'h0000_03FC, 32'hC001_D00D, "lat15_store");
        do_req(2, LOAD,  32'h0000_03FC, 32'h0,         "lat15_load");
        do_req(2, LOAD,  32'h8000_03FC, 32'h0,         "lat15_load_oor");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        logic [31:0] a;
        int pulses, last, cyc;
        bit prev;
        a = 32'h44;
        model_apply(1, LOAD, a, 32'h0, exp);
        exp_q.push_back(exp);
        addr_a[1]  = a;
        type_a[1]  = LOAD;
        valid_a[1] = 1'b1;
        pulses = 0;
        last = 0;
        cyc = 0;
        prev = 1'b0;
        while (pulses < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (fulfilled_a[1] === 1'b1) begin
                n_vec++;
                if (prev) begin
                    n_err++;
                    $display("FAIL b2b_consecutive: got fulfilled high on cycles %0d and %0d, required isolated pulses", cyc - 1, cyc);
                end
                n_vec++;
                if (cyc - last != (pulses == 0 ? 3 : 4)) begin
                    n_err++;
                    $display("FAIL b2b_spacing: got %0d cycles, required %0d", cyc - last, pulses == 0 ? 3 : 4);
                end
                exp = exp_q.pop_front();
                n_vec++;
                if (fetched_a[1] !== exp) begin
                    n_err++;
                    $display("FAIL b2b_data: got %h, required %h", fetched_a[1], exp);
                end
                last = cyc;
                pulses++;
                if (pulses < 6) begin
                    a = (a == 32'h44) ? 32'h80 : 32'h44;
                    model_apply(1, LOAD, a, 32'h0, exp);
                    exp_q.push_back(exp);
                    addr_a[1] = a;
                end else begin
                    valid_a[1] = 1'b0;
                end
            end
            prev = fulfilled_a[1];
        end
        n_vec++;
        if (pulses != 6) begin
            n_err++;
            $display("FAIL b2b_count: got %0d responses, required 6", pulses);
        end
        valid_a[1] = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_request();
        addr_a[1]  = 32'h0000_0010;
        type_a[1]  = STORE;
        wdata_a[1] = 32'hCAFE_F00D;
        valid_a[1] = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy_a[1] !== 1'b1) begin
            n_err++;
            $display("FAIL abort_busy: got busy=%b, required 1", busy_a[1]);
        end
        valid_a[1] = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if (busy_a[1] !== 1'b0 || fulfilled_a[1] !== 1'b0 || fetched_a[1] !== 32'h0) begin
            n_err++;
            $display("FAIL abort_async: got busy=%b fulfilled=%b fetched=%h, required 0 0 00000000",
                     busy_a[1], fulfilled_a[1], fetched_a[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (fulfilled_a[1] !== 1'b0) begin
                n_err++;
                $display("FAIL abort_no_pulse: got fulfilled=1 at cycle %0d, required 0", i);
            end
        end
        do_req(1, LOAD, 32'h0000_0010, 32'h0, "load_after_abort");
    endtask

    task automatic test_random();
        logic [31:0] a;
        memory_operation_e op;
        int count;
        for (int d = 0; d < 3; d++) begin
            count = (d == 2) ? 682 : 683;
            for (int n = 0; n < count; n++) begin
                a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(10, 31));
                op = memory_operation_e'($urandom_range(0, 1));
                do_req(d, op, a, $urandom, "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_request();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
